// File: rtl/platform_field.sv
// Playfield platform store: INIT layout, per-frame scroll, bottom-edge respawn and climb score.
// Define DIFFICULTY_RAMP_EN to shrink platforms as the score grows.
module platform_field #(
   parameter int unsigned W           = 640,
   parameter int unsigned H           = 480,
   parameter int unsigned X_MIN       = 140,
   parameter int unsigned X_MAX       = 499,
   parameter int unsigned PLAT_SIZE   = 60,
   parameter int unsigned SPACING     = 60,
   parameter int unsigned SCROLL_LINE = 160,
   parameter int unsigned MAX_SCROLL  = 8,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [1:0]  frame_clk_edge,
   input  logic [7:0]  state,
   input  logic [9:0]  Doodle_Y_in,
   output logic [9:0]  Platform_X [8],
   output logic [9:0]  Platform_Y [8],
   output logic [7:0]  platform_size,
   output logic [3:0]  scroll_dy,
   output logic [15:0] score,
   output logic        busy
);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StInit    = 3'd1;
   localparam logic [2:0] StPlay    = 3'd2;
   localparam logic [2:0] StScroll  = 3'd3;
   localparam logic [2:0] StRespawn = 3'd4;

   localparam logic [9:0] HY       = 10'(H);
   localparam logic [9:0] XCenter  = 10'((W - PLAT_SIZE) / 2);
   localparam logic [9:0] XSpan    = 10'(X_MAX - X_MIN + 1);

   logic [2:0]  fsm_q, fsm_d;
   logic [2:0]  idx_q, idx_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [9:0]  plat_x_q [8];
   logic [9:0]  plat_x_d [8];
   logic [9:0]  plat_y_q [8];
   logic [9:0]  plat_y_d [8];
   logic [3:0]  dy_q, dy_d;
   logic [15:0] score_q, score_d;
   logic [7:0]  size_cur;
   logic [9:0]  x_range, rand_r, rand_x;
   logic [9:0]  dy_diff;
   logic [3:0]  dy_new;
   logic [16:0] score_sum;

`ifdef DIFFICULTY_RAMP_EN
   logic [7:0] size_q, size_d;
   logic [6:0] shrink;

   always_comb begin
      shrink = {score_q[15:10], 1'b0};
      size_d = size_q;
      if (fsm_q == StInit) begin
         size_d = 8'(PLAT_SIZE);
      end else if (fsm_q == StScroll) begin
         size_d = (32'(shrink) + 32'd30 >= PLAT_SIZE) ? 8'd30 : 8'(PLAT_SIZE - 32'(shrink));
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) size_q <= 8'(PLAT_SIZE);
      else          size_q <= size_d;
   end

   assign size_cur = size_q;
`else
   assign size_cur = 8'(PLAT_SIZE);
`endif

   // Single conditional subtract suffices because the X range is at least 256.
   always_comb begin
      x_range = XSpan - {2'b00, size_cur};
      rand_r  = {1'b0, lfsr_q[8:0]};
      if (rand_r >= x_range) rand_r = rand_r - x_range;
      rand_x  = 10'(X_MIN) + rand_r;
   end

   always_comb begin
      dy_diff = 10'(SCROLL_LINE) - Doodle_Y_in;
      if (Doodle_Y_in >= 10'(SCROLL_LINE))   dy_new = 4'd0;
      else if (dy_diff > 10'(MAX_SCROLL))    dy_new = 4'(MAX_SCROLL);
      else                                   dy_new = dy_diff[3:0];
      score_sum = {1'b0, score_q} + 17'(dy_new);
   end

   always_comb begin
      fsm_d    = fsm_q;
      idx_d    = idx_q;
      plat_x_d = plat_x_q;
      plat_y_d = plat_y_q;
      dy_d     = dy_q;
      score_d  = score_q;
      lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      case (fsm_q)
         StIdle: begin
            idx_d = 3'd0;
            if (state == 8'd1) fsm_d = StInit;
         end
         StInit: begin
            plat_y_d[idx_q] = 10'(H - 20 - SPACING * {29'd0, idx_q});
            plat_x_d[idx_q] = (idx_q == 3'd0) ? XCenter : rand_x;
            dy_d            = 4'd0;
            score_d         = 16'd0;
            idx_d           = idx_q + 3'd1;
            if (idx_q == 3'd7) fsm_d = StPlay;
         end
         StPlay: begin
            if (state != 8'd1)                fsm_d = StIdle;
            else if (frame_clk_edge == 2'b01) fsm_d = StScroll;
         end
         StScroll: begin
            // Y never exceeds H + MAX_SCROLL here, so the 10-bit store cannot wrap.
            for (int i = 0; i < 8; i++) begin
               plat_y_d[i] = 10'({1'b0, plat_y_q[i]} + 11'(dy_new));
            end
            dy_d    = dy_new;
            score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            idx_d   = 3'd0;
            fsm_d   = StRespawn;
         end
         StRespawn: begin
            if (plat_y_q[idx_q] >= HY) begin
               plat_y_d[idx_q] = plat_y_q[idx_q] - HY;
               plat_x_d[idx_q] = rand_x;
            end
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) fsm_d = StPlay;
         end
         default: fsm_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         fsm_q   <= StIdle;
         idx_q   <= 3'd0;
         lfsr_q  <= LFSR_SEED;
         dy_q    <= 4'd0;
         score_q <= 16'd0;
         for (int i = 0; i < 8; i++) begin
            plat_x_q[i] <= 10'(X_MIN);
            plat_y_q[i] <= HY;
         end
      end else begin
         fsm_q    <= fsm_d;
         idx_q    <= idx_d;
         lfsr_q   <= lfsr_d;
         dy_q     <= dy_d;
         score_q  <= score_d;
         plat_x_q <= plat_x_d;
         plat_y_q <= plat_y_d;
      end
   end

   assign Platform_X    = plat_x_q;
   assign Platform_Y    = plat_y_q;
   assign platform_size = size_cur;
   assign scroll_dy     = dy_q;
   assign score         = score_q;
   assign busy          = (fsm_q == StInit) || (fsm_q == StScroll) || (fsm_q == StRespawn);

endmodule

// File: tb/tb_platform_field.sv
// Directed bench for platform_field: reset, INIT layout, scrolling, respawn, saturation, aborts.
module tb_platform_field;

   logic        clk;
   logic        rst_n;
   logic [1:0]  frame_edge;
   logic [7:0]  game_state;
   logic [9:0]  doodle_y;
   logic [9:0]  px [8];
   logic [9:0]  py [8];
   logic [7:0]  psize;
   logic [3:0]  sdy;
   logic [15:0] score;
   logic        busy;

   int unsigned n_vec;
   int unsigned n_err;

   logic [15:0] m_lfsr;
   logic [9:0]  m_x [8];
   logic [9:0]  m_y [8];
   logic [15:0] m_score;
   logic [9:0]  exp_rx [8];

   platform_field dut (
      .Clk            (clk),
      .Reset_n        (rst_n),
      .frame_clk_edge (frame_edge),
      .state          (game_state),
      .Doodle_Y_in    (doodle_y),
      .Platform_X     (px),
      .Platform_Y     (py),
      .platform_size  (psize),
      .scroll_dy      (sdy),
      .score          (score),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic logic [9:0] rand_x(input logic [15:0] l);
      logic [9:0] r;
      r = {1'b0, l[8:0]};
      if (r >= 10'd300) r = r - 10'd300;
      return 10'd140 + r;
   endfunction

   // Reference LFSR advancing on every non-reset edge.
   always @(posedge clk) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= lfsr_step(m_lfsr);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s_y%0d", tag, i), 32'(py[i]), 32'd480);
         check($sformatf("%s_x%0d", tag, i), 32'(px[i]), 32'd140);
      end
      check({tag, "_score"}, 32'(score), 32'd0);
      check({tag, "_dy"}, 32'(sdy), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_size"}, 32'(psize), 32'd60);
   endtask

   task automatic check_field(input string tag);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s_y%0d", tag, i), 32'(py[i]), 32'(m_y[i]));
         check($sformatf("%s_x%0d", tag, i), 32'(px[i]), 32'(m_x[i]));
      end
   endtask

   // One frame: pulse the edge, track busy, optionally re-pulse or drop state mid-update.
   task automatic frame(input string tag, input logic [9:0] dy_in, input int exp_dy,
                        input int pulse_at, input int drop_at);
      int c;
      doodle_y   = dy_in;
      frame_edge = 2'b01;
      tick();
      frame_edge = 2'b00;
      c = 0;
      while (busy === 1'b1 && c < 20) begin
         if (c >= 1 && c <= 8) exp_rx[c - 1] = rand_x(m_lfsr);
         if (c == drop_at) game_state = 8'd0;
         frame_edge = (c == pulse_at) ? 2'b01 : 2'b00;
         tick();
         c++;
      end
      frame_edge = 2'b00;
      check({tag, "_busy_cycles"}, 32'(c), 32'd9);
      m_score = (32'(m_score) + 32'(exp_dy) > 32'hFFFF) ? 16'hFFFF : 16'(m_score + 16'(exp_dy));
      for (int i = 0; i < 8; i++) begin
         m_y[i] = m_y[i] + 10'(exp_dy);
         if (m_y[i] >= 10'd480) begin
            m_y[i] = m_y[i] - 10'd480;
            m_x[i] = exp_rx[i];
         end
      end
      check({tag, "_scroll_dy"}, 32'(sdy), 32'(exp_dy));
      check({tag, "_score"}, 32'(score), 32'(m_score));
      check_field(tag);
   endtask

   initial begin
      logic [9:0] init_y [8];
      logic [9:0] exp_x [8];
      int c;
      init_y = '{10'd460, 10'd400, 10'd340, 10'd280, 10'd220, 10'd160, 10'd100, 10'd40};
      n_vec      = 0;
      n_err      = 0;
      rst_n      = 1'b0;
      game_state = 8'd0;
      frame_edge = 2'b00;
      doodle_y   = 10'd300;
      m_score    = 16'd0;

      repeat (3) tick();
      check_reset_values("rst");
      rst_n = 1'b1;
      repeat (2) tick();
      check("idle_y3", 32'(py[3]), 32'd480);
      check("idle_busy", 32'(busy), 32'd0);

      // INIT: one slot per cycle, busy for exactly 8 cycles.
      game_state = 8'd1;
      tick();
      c = 0;
      while (busy === 1'b1 && c < 20) begin
         if (c < 8) exp_x[c] = rand_x(m_lfsr);
         tick();
         c++;
      end
      check("init_busy_cycles", 32'(c), 32'd8);
      check("init_x0", 32'(px[0]), 32'd290);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("init_y%0d", i), 32'(py[i]), 32'(init_y[i]));
         m_y[i] = init_y[i];
         m_x[i] = (i == 0) ? 10'd290 : exp_x[i];
         if (i > 0) begin
            check($sformatf("init_x%0d", i), 32'(px[i]), 32'(exp_x[i]));
            check($sformatf("init_xrange%0d", i), 32'(px[i] >= 10'd140 && px[i] <= 10'd439), 32'd1);
         end
      end
      check("init_score", 32'(score), 32'd0);

      frame("f1", 10'd155, 5, -1, -1);
      check("f1_y0", 32'(py[0]), 32'd465);
      check("f1_score_hand", 32'(score), 32'd5);
      frame("f2", 10'd100, 8, -1, -1);
      check("f2_y0", 32'(py[0]), 32'd473);
      frame("f3", 10'd200, 0, -1, -1);
      check("f3_y0", 32'(py[0]), 32'd473);
      frame("f4", 10'd157, 3, -1, -1);
      check("f4_y0", 32'(py[0]), 32'd476);
      check("f4_score_hand", 32'(score), 32'd16);
      frame("f5", 10'd100, 8, -1, -1);
      check("f5_y0_wrap", 32'(py[0]), 32'd4);
      check("f5_x0_range", 32'(px[0] >= 10'd140 && px[0] <= 10'd439), 32'd1);
      check("f5_y1", 32'(py[1]), 32'd424);

      // Preset score near saturation while sitting in PLAY.
      force dut.score_q = 16'd65530;
      tick();
      release dut.score_q;
      m_score = 16'd65530;
      check("preset_score", 32'(score), 32'd65530);
      frame("sat", 10'd100, 8, 3, -1);
      check("sat_score_hand", 32'(score), 32'd65535);
      repeat (3) tick();
      check("sat_no_requeue_busy", 32'(busy), 32'd0);
      check_field("sat_hold");

      // Dropping state mid-RESPAWN lets the update finish, then the block idles.
      frame("drop", 10'd152, 8, -1, 4);
      frame_edge = 2'b01;
      repeat (3) tick();
      frame_edge = 2'b00;
      check("idle_ignores_edge", 32'(busy), 32'd0);
      check("idle_dy_hold", 32'(sdy), 32'd8);
      check_field("idle_hold");

      // Reset asserted mid-INIT aborts immediately.
      game_state = 8'd1;
      repeat (4) tick();
      check("reinit_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      check_reset_values("abort");
      game_state = 8'd0;
      rst_n = 1'b1;
      tick();
      check("post_abort_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
